// File: rtl/reaction_round_fsm.sv
// ---------------------------------------------------------------------------
// reaction_round_fsm
//
// Round controller for the reaction timer. One round runs like this: arm on
// start, wait a pseudo-random delay, light the stimulus LED, then count
// milliseconds until the react button is pressed. The round state and the
// measured time are published every cycle for the high-score tracker and the
// display.
//
// Parameters:
//   MIN_DELAY_MS  fixed part of the pre-stimulus delay, in ms
//   MAX_TIME_MS   reaction-time ceiling, in ms (must fit in 14 bits)
//
// Ports:
//   clock          in   1  system clock, rising edge
//   reset          in   1  synchronous, active-high reset
//   ms_tick        in   1  1 kHz strobe, one clock cycle wide
//   start          in   1  debounced start pulse
//   react          in   1  debounced react-button pulse
//   random_delay   in  14  free-running LFSR value, bits [11:0] used
//   current_state  out  3  round state (IDLE=0 .. RESULT_SLOW=5)
//   reaction_time  out 14  measured reaction time in ms, registered
//   stimulus_led   out  1  stimulus LED, registered
// ---------------------------------------------------------------------------
module reaction_round_fsm #(
  parameter int MIN_DELAY_MS = 1000,
  parameter int MAX_TIME_MS  = 9999
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        ms_tick,
  input  logic        start,
  input  logic        react,
  input  logic [13:0] random_delay,
  output logic [2:0]  current_state,
  output logic [13:0] reaction_time,
  output logic        stimulus_led
);

  typedef enum logic [2:0] {
    STATE_IDLE         = 3'd0,
    STATE_WAITING      = 3'd1,
    STATE_TIMING       = 3'd2,
    STATE_RESULT_OK    = 3'd3,
    STATE_RESULT_EARLY = 3'd4,
    STATE_RESULT_SLOW  = 3'd5
  } state_t;

  localparam logic [13:0] MinDelay = 14'(MIN_DELAY_MS);
  localparam logic [13:0] MaxTime  = 14'(MAX_TIME_MS);

  state_t      r_state;
  state_t      w_nextState;
  logic [13:0] r_delay;
  logic [13:0] r_time;
  logic        r_led;
  logic [13:0] w_nextDelay;
  logic [13:0] w_nextTime;
  logic [13:0] w_loadDelay;
  logic        w_unusedRandomHigh;

  // Only the low 12 LFSR bits shape the delay; the top two are deliberately
  // dropped so the delay stays within 1000..5095 ms.
  assign w_loadDelay        = MinDelay + {2'b00, random_delay[11:0]};
  assign w_unusedRandomHigh = ^random_delay[13:12];

  // State register. The LED is derived from the next state so it rises on
  // the same edge that TIMING is entered and falls on the edge that leaves it.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= STATE_IDLE;
      r_led   <= 1'b0;
    end else begin
      r_state <= w_nextState;
      r_led   <= (w_nextState == STATE_TIMING);
    end
  end

  // Next-state logic. react takes priority over a coincident tick in both
  // WAITING (early press wins over the final delay tick) and TIMING (press
  // wins over the ceiling tick). Codes 6 and 7 fall back to IDLE.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      STATE_IDLE: begin
        if (start) w_nextState = STATE_WAITING;
      end
      STATE_WAITING: begin
        if (react)                              w_nextState = STATE_RESULT_EARLY;
        else if (ms_tick && (r_delay <= 14'd1)) w_nextState = STATE_TIMING;
      end
      STATE_TIMING: begin
        if (react)                               w_nextState = STATE_RESULT_OK;
        else if (ms_tick && (r_time >= MaxTime)) w_nextState = STATE_RESULT_SLOW;
      end
      STATE_RESULT_OK, STATE_RESULT_EARLY, STATE_RESULT_SLOW: begin
        if (start) w_nextState = STATE_WAITING;
      end
      default: w_nextState = STATE_IDLE;
    endcase
  end

  // Output/datapath next values. Result states hold reaction_time untouched
  // until a new start; both counters saturate instead of wrapping.
  always_comb begin
    w_nextDelay = r_delay;
    w_nextTime  = r_time;
    case (r_state)
      STATE_IDLE, STATE_RESULT_OK, STATE_RESULT_EARLY, STATE_RESULT_SLOW: begin
        if (start) begin
          w_nextDelay = w_loadDelay;
          w_nextTime  = 14'd0;
        end
      end
      STATE_WAITING: begin
        if (!react && ms_tick && (r_delay != 14'd0)) w_nextDelay = r_delay - 14'd1;
      end
      STATE_TIMING: begin
        if (!react && ms_tick && (r_time < MaxTime)) w_nextTime = r_time + 14'd1;
      end
      default: begin
        w_nextDelay = 14'd0;
        w_nextTime  = 14'd0;
      end
    endcase
  end

  // Datapath registers for the delay counter and the reaction time.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_delay <= 14'd0;
      r_time  <= 14'd0;
    end else begin
      r_delay <= w_nextDelay;
      r_time  <= w_nextTime;
    end
  end

  assign current_state = r_state;
  assign reaction_time = r_time;
  assign stimulus_led  = r_led;

endmodule

// File: tb/tb_reaction_round_fsm.sv
// ---------------------------------------------------------------------------
// tb_reaction_round_fsm
//
// Directed testbench for reaction_round_fsm with default parameters
// (MIN_DELAY_MS = 1000, MAX_TIME_MS = 9999). Each scenario task drives
// stimulus and compares {current_state, reaction_time, stimulus_led}
// against hand-computed values.
// ---------------------------------------------------------------------------
module tb_reaction_round_fsm;

  logic        clock;
  logic        reset;
  logic        ms_tick;
  logic        start;
  logic        react;
  logic [13:0] random_delay;
  logic [2:0]  current_state;
  logic [13:0] reaction_time;
  logic        stimulus_led;

  int vectors;
  int miscompares;

  reaction_round_fsm dut (
    .clock         (clock),
    .reset         (reset),
    .ms_tick       (ms_tick),
    .start         (start),
    .react         (react),
    .random_delay  (random_delay),
    .current_state (current_state),
    .reaction_time (reaction_time),
    .stimulus_led  (stimulus_led)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // One clock cycle with the given pulses; inputs change 1 ns after the
  // rising edge and outputs are observed at that same point.
  task automatic applyStimulus(input logic t, input logic s, input logic r);
    ms_tick = t;
    start   = s;
    react   = r;
    @(posedge clock);
    #1;
    ms_tick = 1'b0;
    start   = 1'b0;
    react   = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_reset;
    reset = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0);
    reset = 1'b0;
    vectors++;
    if ({current_state, reaction_time, stimulus_led} !== {3'd0, 14'd0, 1'b0}) begin
      miscompares++;
      $display("[TB] FAIL reset: got state=%0d time=%0d led=%0d, expected 0/0/0",
               current_state, reaction_time, stimulus_led);
    end
  endtask

  task automatic test_ok_round;
    random_delay = 14'h0005;
    applyStimulus(1'b0, 1'b1, 1'b0);
    vectors++;
    if ({current_state, reaction_time, stimulus_led} !== {3'd1, 14'd0, 1'b0}) begin
      miscompares++;
      $display("[TB] FAIL ok_armed: got state=%0d time=%0d led=%0d, expected 1/0/0",
               current_state, reaction_time, stimulus_led);
    end
    ticks(1004);
    vectors++;
    if ({current_state, reaction_time, stimulus_led} !== {3'd1, 14'd0, 1'b0}) begin
      miscompares++;
      $display("[TB] FAIL ok_tick1004: got state=%0d time=%0d led=%0d, expected 1/0/0",
               current_state, reaction_time, stimulus_led);
    end
    ticks(1);
    vectors++;
    if ({current_state, reaction_time, stimulus_led} !== {3'd2, 14'd0, 1'b1}) begin
      miscompares++;
      $display("[TB] FAIL ok_stimulus: got state=%0d time=%0d led=%0d, expected 2/0/1",
               current_state, reaction_time, stimulus_led);
    end
    ticks(250);
    vectors++;
    if ({current_state, reaction_time, stimulus_led} !== {3'd2, 14'd250, 1'b1}) begin
      miscompares++;
      $display("[TB] FAIL ok_timing250: got state=%0d time=%0d led=%0d, expected 2/250/1",
               current_state, reaction_time, stimulus_led);
    end
    applyStimulus(1'b0, 1'b0, 1'b1);
    vectors++;
    if ({current_state, reaction_time, stimulus_led} !== {3'd3, 14'd250, 1'b0}) begin
      miscompares++;
      $display("[TB] FAIL ok_result: got state=%0d time=%0d led=%0d, expected 3/250/0",
               current_state, reaction_time, stimulus_led);
    end
    for (int i = 0; i < 100; i++) begin
      applyStimulus(1'b1, 1'b0, (i % 7) == 3);
      vectors++;
      if ({current_state, reaction_time, stimulus_led} !== {3'd3, 14'd250, 1'b0}) begin
        miscompares++;
        $display("[TB] FAIL ok_hold[%0d]: got state=%0d time=%0d led=%0d, expected 3/250/0",
                 i, current_state, reaction_time, stimulus_led);
      end
    end
  endtask

  task automatic test_early;
    logic ledSeen;
    // Upper LFSR bits set: delay must still be 1005 ticks.
    random_delay = 14'h3005;
    ledSeen = 1'b0;
    applyStimulus(1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b0);
      ledSeen = ledSeen | stimulus_led;
    end
    applyStimulus(1'b0, 1'b0, 1'b1);
    ledSeen = ledSeen | stimulus_led;
    vectors++;
    if ({current_state, reaction_time, ledSeen} !== {3'd4, 14'd0, 1'b0}) begin
      miscompares++;
      $display("[TB] FAIL early_react: got state=%0d time=%0d ledSeen=%0d, expected 4/0/0",
               current_state, reaction_time, ledSeen);
    end
    // react on the same cycle as the final (1005th) delay tick.
    ledSeen = 1'b0;
    applyStimulus(1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 1004; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b0);
      ledSeen = ledSeen | stimulus_led;
    end
    vectors++;
    if ({current_state, ledSeen} !== {3'd1, 1'b0}) begin
      miscompares++;
      $display("[TB] FAIL early_hiupper: got state=%0d ledSeen=%0d, expected 1/0",
               current_state, ledSeen);
    end
    applyStimulus(1'b1, 1'b0, 1'b1);
    ticks(3);
    vectors++;
    if ({current_state, reaction_time, stimulus_led} !== {3'd4, 14'd0, 1'b0}) begin
      miscompares++;
      $display("[TB] FAIL early_coincident: got state=%0d time=%0d led=%0d, expected 4/0/0",
               current_state, reaction_time, stimulus_led);
    end
  endtask

  task automatic test_slow;
    random_delay = 14'h0000;
    applyStimulus(1'b0, 1'b1, 1'b0);
    ticks(1000);
    vectors++;
    if ({current_state, reaction_time, stimulus_led} !== {3'd2, 14'd0, 1'b1}) begin
      miscompares++;
      $display("[TB] FAIL slow_enter: got state=%0d time=%0d led=%0d, expected 2/0/1",
               current_state, reaction_time, stimulus_led);
    end
    ticks(9999);
    vectors++;
    if ({current_state, reaction_time, stimulus_led} !== {3'd2, 14'd9999, 1'b1}) begin
      miscompares++;
      $display("[TB] FAIL slow_ceiling: got state=%0d time=%0d led=%0d, expected 2/9999/1",
               current_state, reaction_time, stimulus_led);
    end
    ticks(1);
    vectors++;
    if ({current_state, reaction_time, stimulus_led} !== {3'd5, 14'd9999, 1'b0}) begin
      miscompares++;
      $display("[TB] FAIL slow_result: got state=%0d time=%0d led=%0d, expected 5/9999/0",
               current_state, reaction_time, stimulus_led);
    end
    applyStimulus(1'b1, 1'b0, 1'b1);
    vectors++;
    if ({current_state, reaction_time, stimulus_led} !== {3'd5, 14'd9999, 1'b0}) begin
      miscompares++;
      $display("[TB] FAIL slow_hold: got state=%0d time=%0d led=%0d, expected 5/9999/0",
               current_state, reaction_time, stimulus_led);
    end
  endtask

  task automatic test_react_with_tick;
    random_delay = 14'h0000;
    applyStimulus(1'b0, 1'b1, 1'b0);
    vectors++;
    if ({current_state, reaction_time, stimulus_led} !== {3'd1, 14'd0, 1'b0}) begin
      miscompares++;
      $display("[TB] FAIL rt_restart: got state=%0d time=%0d led=%0d, expected 1/0/0",
               current_state, reaction_time, stimulus_led);
    end
    ticks(1000);
    ticks(37);
    applyStimulus(1'b1, 1'b0, 1'b1);
    vectors++;
    if ({current_state, reaction_time, stimulus_led} !== {3'd3, 14'd37, 1'b0}) begin
      miscompares++;
      $display("[TB] FAIL rt_coincident: got state=%0d time=%0d led=%0d, expected 3/37/0",
               current_state, reaction_time, stimulus_led);
    end
    applyStimulus(1'b0, 1'b1, 1'b0);
    vectors++;
    if ({current_state, reaction_time, stimulus_led} !== {3'd1, 14'd0, 1'b0}) begin
      miscompares++;
      $display("[TB] FAIL rt_next_start: got state=%0d time=%0d led=%0d, expected 1/0/0",
               current_state, reaction_time, stimulus_led);
    end
  endtask

  task automatic test_reset_mid;
    // Block is in WAITING from the previous task.
    ticks(300);
    reset = 1'b1;
    applyStimulus(1'b1, 1'b1, 1'b0);
    reset = 1'b0;
    vectors++;
    if ({current_state, reaction_time, stimulus_led} !== {3'd0, 14'd0, 1'b0}) begin
      miscompares++;
      $display("[TB] FAIL rst_waiting: got state=%0d time=%0d led=%0d, expected 0/0/0",
               current_state, reaction_time, stimulus_led);
    end
    for (int i = 0; i < 20; i++) applyStimulus(1'b1, 1'b0, i[0]);
    vectors++;
    if ({current_state, reaction_time, stimulus_led} !== {3'd0, 14'd0, 1'b0}) begin
      miscompares++;
      $display("[TB] FAIL rst_idle_a: got state=%0d time=%0d led=%0d, expected 0/0/0",
               current_state, reaction_time, stimulus_led);
    end
    // Largest delay: 1000 + 4095 = 5095 ticks.
    random_delay = 14'h0FFF;
    applyStimulus(1'b0, 1'b1, 1'b0);
    ticks(5094);
    vectors++;
    if ({current_state, stimulus_led} !== {3'd1, 1'b0}) begin
      miscompares++;
      $display("[TB] FAIL rst_maxdelay_wait: got state=%0d led=%0d, expected 1/0",
               current_state, stimulus_led);
    end
    ticks(1);
    ticks(20);
    vectors++;
    if ({current_state, reaction_time, stimulus_led} !== {3'd2, 14'd20, 1'b1}) begin
      miscompares++;
      $display("[TB] FAIL rst_maxdelay_timing: got state=%0d time=%0d led=%0d, expected 2/20/1",
               current_state, reaction_time, stimulus_led);
    end
    reset = 1'b1;
    applyStimulus(1'b1, 1'b0, 1'b1);
    reset = 1'b0;
    vectors++;
    if ({current_state, reaction_time, stimulus_led} !== {3'd0, 14'd0, 1'b0}) begin
      miscompares++;
      $display("[TB] FAIL rst_timing: got state=%0d time=%0d led=%0d, expected 0/0/0",
               current_state, reaction_time, stimulus_led);
    end
    for (int i = 0; i < 20; i++) applyStimulus(1'b1, 1'b0, i[0]);
    vectors++;
    if ({current_state, reaction_time, stimulus_led} !== {3'd0, 14'd0, 1'b0}) begin
      miscompares++;
      $display("[TB] FAIL rst_idle_b: got state=%0d time=%0d led=%0d, expected 0/0/0",
               current_state, reaction_time, stimulus_led);
    end
  endtask

  initial begin
    vectors      = 0;
    miscompares  = 0;
    reset        = 1'b1;
    ms_tick      = 1'b0;
    start        = 1'b0;
    react        = 1'b0;
    random_delay = 14'h0000;
    @(posedge clock);
    #1;
    test_reset();
    test_ok_round();
    test_early();
    test_slow();
    test_react_with_tick();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/reaction_round_fsm.md
# reaction_round_fsm

Round controller for the reaction timer; sits directly upstream of the high-score tracker. Sequences one measurement round: arm on start, wait a pseudo-random delay, light the stimulus LED, count milliseconds until the react button is pressed. Publishes `current_state` and `reaction_time`, which the high-score tracker and the display sample every cycle.

## Interface
Parameters:
- `MIN_DELAY_MS`, default 1000: fixed part of the pre-stimulus delay, in ms.
- `MAX_TIME_MS`, default 9999: reaction-time ceiling, in ms. It must fit in 14 bits.

Ports:
- `clock`  in  1: system clock. All logic is on the rising edge.
- `reset`  in  1: reset, synchronous and active-high.
- `ms_tick`  in  1: 1 kHz strobe, high for one `clock` cycle.
- `start`  in  1: debounced start pulse, one cycle wide.
- `react`  in  1: debounced react-button pulse, one cycle wide.
- `random_delay`  in  14: free-running LFSR value. Only bits [11:0] are used.
- `current_state`  out  3: round state, using the shared state macros.
- `reaction_time`  out  14: measured time in ms, registered.
- `stimulus_led`  out  1: stimulus LED, registered.

## Operation
State encodings (shared macros):
- `STATE_IDLE` = 0
- `STATE_WAITING` = 1
- `STATE_TIMING` = 2
- `STATE_RESULT_OK` = 3
- `STATE_RESULT_EARLY` = 4
- `STATE_RESULT_SLOW` = 5
- Codes 6 and 7 are unreachable. If either is ever entered, go to `STATE_IDLE` on the next edge.

Reset:
- `current_state` = `STATE_IDLE`, `reaction_time` = 0, `stimulus_led` = 0.
- Internal delay counter = 0.
- Reset overrides every other input in the same cycle.

IDLE:
- `start` → WAITING.
- Load delay counter = `MIN_DELAY_MS` + `random_delay[11:0]`, zero-extended to 14 bits. Range is 1000..5095.
- Clear `reaction_time` to 0.

WAITING:
- Each `ms_tick` decrements the delay counter.
- `react` → RESULT_EARLY. `reaction_time` stays 0.
- A tick that finds the counter at 1 → TIMING, and `stimulus_led` is set to 1.
- If `react` and that final tick occur together, `react` wins: go to RESULT_EARLY and leave the LED off.

TIMING:
- Each `ms_tick` increments `reaction_time`.
- `react` → RESULT_OK. `reaction_time` freezes, and a tick in the same cycle is not counted.
- A tick while `reaction_time` == `MAX_TIME_MS` (and no `react`) → RESULT_SLOW. `reaction_time` holds at `MAX_TIME_MS`.
- `stimulus_led` clears on leaving TIMING.

RESULT_OK / RESULT_EARLY / RESULT_SLOW:
- `reaction_time` and `current_state` are held constant every cycle. The high-score tracker relies on this.
- `react` and `ms_tick` are ignored.
- `start` → WAITING: reload the delay counter and clear `reaction_time`, exactly as from IDLE.

Other rules:
- `start` is ignored in WAITING and TIMING.
- Arithmetic is 14-bit unsigned. The increment never exceeds `MAX_TIME_MS`, and the decrement never goes below 0.

## Timing
- Every output is a register. An input pulse sampled on edge N appears on the outputs after edge N; there is no combinational input-to-output path.
- `reaction_time` equals the number of `ms_tick` pulses sampled while in TIMING, excluding a tick coincident with `react`. The minimum OK result is 0.
- `stimulus_led` goes high on the same edge that `current_state` becomes `STATE_TIMING`. It goes low on the same edge that the state leaves TIMING.
- Pre-stimulus delay, measured from the start edge, is exactly `MIN_DELAY_MS` + `random_delay[11:0]` ticks.
- Reset asserted mid-round: on the next edge the block is in IDLE with all outputs 0. It takes no further action until `start`.

## Test plan
- Reset, then `start` with `random_delay` = 14'h0005:
  - `current_state` = 1 one cycle later.
  - After 1005 ticks: `current_state` = 2 and `stimulus_led` = 1.
- Continuing: 250 ticks, then `react` → `current_state` = 3 and `reaction_time` = 250, held for 100 further cycles with ticks running.
- `react` pulsed 10 ticks after `start`:
  - `current_state` = 4, `reaction_time` = 0, `stimulus_led` never goes high.
  - Repeat with `react` on the same cycle as the final delay tick → still 4 with the LED low.
- In TIMING, no `react` for 10000 ticks:
  - `reaction_time` reaches 9999.
  - The next tick gives `current_state` = 5, `reaction_time` = 9999, `stimulus_led` = 0.
- In TIMING at 37 ms, `react` and `ms_tick` in the same cycle → `reaction_time` = 37, state 3. A following `start` → state 1 and `reaction_time` = 0.
- `reset` asserted in the middle of WAITING and again in the middle of TIMING → next edge gives state 0, time 0, LED 0. A `start` held off still leaves the block in IDLE.
